commit_ctrl: RTL and testbench

COMMIT_CTRL -- requirements
Module: commit_ctrl

---
 rtl/commit_ctrl_pkg.sv | 21 ++
 rtl/commit_ctrl.sv | 116 +++++++++++
 tb/tb_commit_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_ctrl_pkg.sv
// rtl/commit_ctrl_pkg.sv - shared ROB width, head-type and commit FSM encodings
package commit_ctrl_pkg;

  localparam int ROB_ADDR_W = 4;

  typedef enum logic [1:0] {
    HT_REG    = 2'd0,
    HT_STORE  = 2'd1,
    HT_BRANCH = 2'd2,
    HT_EXIT   = 2'd3
  } head_type_e;

  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_STORE_WAIT  = 3'd1,
    ST_FLUSH_ISSUE = 3'd2,
    ST_FLUSH_DRAIN = 3'd3,
    ST_HALT        = 3'd4
  } commit_state_e;

endpackage

// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order ROB head commit: regfile writeback, store handshake, mispredict flush, halt
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int RoB_addr = ROB_ADDR_W
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                head_valid,
  input  logic                head_ready,
  input  logic [1:0]          head_type,
  input  logic [4:0]          head_rd,
  input  logic [31:0]         head_value,
  input  logic [RoB_addr-1:0] head_robidx,
  input  logic                head_mispredict,
  input  logic [31:0]         head_target,
  output logic                head_pop,
  output logic                commit_valid,
  output logic [4:0]          cdb_regid,
  output logic [31:0]         cdb_value,
  output logic [RoB_addr-1:0] cdb_RoBindex,
  output logic                rf_clear,
  output logic                flush_valid,
  output logic [31:0]         flush_pc,
  output logic                store_commit_req,
  input  logic                store_done,
  output logic                halt,
  output logic [31:0]         commit_count
);

  commit_state_e state;
  logic [31:0]   target_q;

  // A pop is suppressed while stalled or in reset so the counter never misses one.
  always_comb begin
    head_pop = 1'b0;
    if (rst_n_in && rdy_in) begin
      case (state)
        ST_RUN:        head_pop = head_valid && head_ready && (head_type != HT_STORE);
        ST_STORE_WAIT: head_pop = store_done;
        default:       head_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= ST_RUN;
      target_q         <= '0;
      commit_valid     <= 1'b0;
      cdb_regid        <= '0;
      cdb_value        <= '0;
      cdb_RoBindex     <= '0;
      rf_clear         <= 1'b0;
      flush_valid      <= 1'b0;
      flush_pc         <= '0;
      store_commit_req <= 1'b0;
      halt             <= 1'b0;
      commit_count     <= '0;
    end else if (rdy_in) begin
      commit_valid <= 1'b0;
      commit_count <= commit_count + {31'd0, head_pop};
      case (state)
        ST_RUN: begin
          if (head_valid && head_ready) begin
            case (head_type)
              HT_REG, HT_BRANCH: begin
                if (head_rd != 5'd0) begin
                  commit_valid <= 1'b1;
                  cdb_regid    <= head_rd;
                  cdb_value    <= head_value;
                  cdb_RoBindex <= head_robidx;
                end
                // The link write commits now; the flush follows one cycle later.
                if (head_type == HT_BRANCH && head_mispredict) begin
                  state    <= ST_FLUSH_ISSUE;
                  target_q <= head_target;
                end
              end
              HT_STORE: begin
                state            <= ST_STORE_WAIT;
                store_commit_req <= 1'b1;
              end
              HT_EXIT: begin
                halt  <= 1'b1;
                state <= ST_HALT;
              end
              default: state <= ST_RUN;
            endcase
          end
        end
        ST_STORE_WAIT: begin
          if (store_done) begin
            state            <= ST_RUN;
            store_commit_req <= 1'b0;
          end
        end
        ST_FLUSH_ISSUE: begin
          rf_clear    <= 1'b1;
          flush_valid <= 1'b1;
          flush_pc    <= target_q;
          state       <= ST_FLUSH_DRAIN;
        end
        ST_FLUSH_DRAIN: begin
          rf_clear    <= 1'b0;
          flush_valid <= 1'b0;
          state       <= ST_RUN;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// tb/tb_commit_ctrl.sv - directed and randomized checks of commit_ctrl against a behavioural model
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  localparam int RW = ROB_ADDR_W;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          head_valid = 1'b0;
  logic          head_ready = 1'b0;
  logic [1:0]    head_type = 2'd0;
  logic [4:0]    head_rd = 5'd0;
  logic [31:0]   head_value = '0;
  logic [RW-1:0] head_robidx = '0;
  logic          head_mispredict = 1'b0;
  logic [31:0]   head_target = '0;
  logic          store_done = 1'b0;
  logic          head_pop, commit_valid, rf_clear, flush_valid, store_commit_req, halt;
  logic [4:0]    cdb_regid;
  logic [31:0]   cdb_value, flush_pc, commit_count;
  logic [RW-1:0] cdb_RoBindex;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: modes of the commit stage and the outputs they imply.
  bit            m_halt, m_swait, m_cv, m_rfc, m_fv, m_req;
  int            m_flush_left;
  logic [31:0]   m_tgt, m_pc, m_count, m_val;
  logic [4:0]    m_rd;
  logic [RW-1:0] m_idx;

  commit_ctrl #(.RoB_addr(RW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
    .head_rd(head_rd), .head_value(head_value), .head_robidx(head_robidx),
    .head_mispredict(head_mispredict), .head_target(head_target),
    .head_pop(head_pop), .commit_valid(commit_valid), .cdb_regid(cdb_regid),
    .cdb_value(cdb_value), .cdb_RoBindex(cdb_RoBindex), .rf_clear(rf_clear),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .store_commit_req(store_commit_req), .store_done(store_done),
    .halt(halt), .commit_count(commit_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halt = 0; m_swait = 0; m_cv = 0; m_rfc = 0; m_fv = 0; m_req = 0;
    m_flush_left = 0; m_tgt = '0; m_pc = '0; m_count = '0;
    m_val = '0; m_rd = '0; m_idx = '0;
  endtask

  function automatic bit model_pop();
    if (!rst_n_in || !rdy_in || m_halt || m_flush_left > 0) return 1'b0;
    if (m_swait) return store_done;
    return head_valid && head_ready && (head_type != 2'd1);
  endfunction

  task automatic model_clock(input bit pop);
    if (!rdy_in) return;
    m_cv = 0;
    if (m_flush_left == 2) begin
      m_rfc = 1; m_fv = 1; m_pc = m_tgt; m_flush_left = 1;
    end else if (m_flush_left == 1) begin
      m_rfc = 0; m_fv = 0; m_flush_left = 0;
    end else if (m_swait) begin
      if (store_done) begin m_swait = 0; m_req = 0; end
    end else if (!m_halt && head_valid && head_ready) begin
      if (head_type == 2'd1) begin
        m_swait = 1; m_req = 1;
      end else if (head_type == 2'd3) begin
        m_halt = 1;
      end else begin
        if (head_rd != 5'd0) begin
          m_cv = 1; m_rd = head_rd; m_val = head_value; m_idx = head_robidx;
        end
        if (head_type == 2'd2 && head_mispredict) begin
          m_flush_left = 2; m_tgt = head_target;
        end
      end
    end
    if (pop) m_count = m_count + 32'd1;
  endtask

  task automatic chk_regs();
    chk("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
    if (m_cv) begin
      chk("cdb_regid", {27'd0, cdb_regid}, {27'd0, m_rd});
      chk("cdb_value", cdb_value, m_val);
      chk("cdb_robindex", 32'(cdb_RoBindex), 32'(m_idx));
    end
    chk("rf_clear", {31'd0, rf_clear}, {31'd0, m_rfc});
    chk("flush_valid", {31'd0, flush_valid}, {31'd0, m_fv});
    if (m_fv) chk("flush_pc", flush_pc, m_pc);
    chk("clear_with_commit", {31'd0, rf_clear & commit_valid}, 32'd0);
    chk("store_commit_req", {31'd0, store_commit_req}, {31'd0, m_req});
    chk("halt", {31'd0, halt}, {31'd0, m_halt});
    chk("commit_count", commit_count, m_count);
  endtask

  task automatic chk_all_zero();
    chk("rst_pop", {31'd0, head_pop}, 32'd0);
    chk("rst_cv", {31'd0, commit_valid}, 32'd0);
    chk("rst_cdb", {cdb_regid, 27'd0} | cdb_value | 32'(cdb_RoBindex), 32'd0);
    chk("rst_flush", {30'd0, rf_clear, flush_valid} | flush_pc, 32'd0);
    chk("rst_req_halt", {30'd0, store_commit_req, halt}, 32'd0);
    chk("rst_count", commit_count, 32'd0);
  endtask

  task automatic step();
    bit p;
    #1;
    p = model_pop();
    chk("head_pop", {31'd0, head_pop}, {31'd0, p});
    model_clock(p);
    @(negedge clk_in);
    chk_regs();
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #1;
    model_reset();
    chk_all_zero();
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic set_head(input bit v, input bit r, input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] val, input logic [RW-1:0] idx, input bit mp,
                          input logic [31:0] tgt);
    head_valid = v; head_ready = r; head_type = t; head_rd = rd; head_value = val;
    head_robidx = idx; head_mispredict = mp; head_target = tgt;
  endtask

  initial begin
    int req_cycles;
    int r;
    model_reset();
    #1;
    chk_all_zero();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // REG writeback with one-cycle latency
    set_head(1, 1, 2'd0, 5'd5, 32'hDEADBEEF, 4'd3, 0, 32'h0);
    step();
    chk("reg_count_one", commit_count, 32'd1);
    set_head(0, 0, 2'd0, 5'd0, 32'h0, 4'd0, 0, 32'h0);
    step();

    // mispredicted branch: commit, then flush, with the next head held off
    set_head(1, 1, 2'd2, 5'd1, 32'h44, 4'd7, 1, 32'h100);
    step();
    set_head(1, 1, 2'd0, 5'd9, 32'h1234, 4'd8, 0, 32'h0);
    step();
    step();
    chk("flush_pc_target", flush_pc, 32'h100);
    step();

    // correctly predicted branch stays in RUN
    set_head(1, 1, 2'd2, 5'd2, 32'h55, 4'd1, 0, 32'h200);
    step();
    step();

    // store handshake with store_done late by four cycles
    set_head(1, 1, 2'd1, 5'd3, 32'h66, 4'd2, 0, 32'h0);
    store_done = 1'b0;
    step();
    req_cycles = int'(store_commit_req);
    for (int i = 0; i < 4; i++) begin
      step();
      req_cycles += int'(store_commit_req);
    end
    store_done = 1'b1;
    set_head(0, 0, 2'd0, 5'd0, 32'h0, 4'd0, 0, 32'h0);
    step();
    store_done = 1'b0;
    chk("store_req_cycles", 32'(req_cycles), 32'd5);

    // store_done outside STORE_WAIT has no effect
    store_done = 1'b1;
    step();
    store_done = 1'b0;

    // rdy_in low freezes everything
    set_head(1, 1, 2'd0, 5'd4, 32'h77, 4'd4, 0, 32'h0);
    rdy_in = 1'b0;
    step();
    step();
    rdy_in = 1'b1;
    step();

    // rd=0 then EXIT, then nothing further pops
    set_head(1, 1, 2'd0, 5'd0, 32'h88, 4'd5, 0, 32'h0);
    step();
    set_head(1, 1, 2'd3, 5'd0, 32'h0, 4'd6, 0, 32'h0);
    step();
    set_head(1, 1, 2'd0, 5'd6, 32'h99, 4'd7, 0, 32'h0);
    for (int i = 0; i < 3; i++) step();

    // reset in the middle of a store handshake
    do_reset();
    set_head(1, 1, 2'd1, 5'd0, 32'h0, 4'd0, 0, 32'h0);
    step();
    step();
    do_reset();
    set_head(1, 1, 2'd0, 5'd7, 32'hA5A5A5A5, 4'd9, 0, 32'h0);
    step();

    // counter wrap from all ones
    set_head(0, 0, 2'd0, 5'd0, 32'h0, 4'd0, 0, 32'h0);
    #1;
    force dut.commit_count = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count;
    m_count = 32'hFFFF_FFFF;
    @(negedge clk_in);
    chk("count_preload", commit_count, 32'hFFFF_FFFF);
    set_head(1, 1, 2'd0, 5'd8, 32'h1, 4'd1, 0, 32'h0);
    step();
    chk("count_wrap", commit_count, 32'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      r = int'($urandom_range(0, 49));
      set_head($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               (r == 0) ? 2'd3 : (r < 12) ? 2'd1 : (r < 30) ? 2'd2 : 2'd0,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               $urandom, RW'($urandom), $urandom_range(0, 1) == 1, $urandom);
      store_done = ($urandom_range(0, 9) < 3);
      step();
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
    end
    rdy_in = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
